vga_sync: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Derives a 25 MHz pixel enable and runs the horizontal and vertical counters.
- Outputs pixel_x, pixel_y and video_on to the pixel generation circuit, and hsync/vsync to the connector.
- It is the timing source that the rgb pipeline consumes.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_pixel_tick.sv | 28 ++
 rtl/vga_sync.sv | 96 +++++++++
 tb/tb_vga_sync.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and coordinate width shared by the vga_sync slice
package vga_timing_pkg;
   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
   localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int VS_END   = VS_START + DEF_V_SYNC - 1;
   localparam int COORD_W  = 10;
endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides the system clock by CLK_DIV into a registered one-clk pixel tick
module vga_pixel_tick
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic o_p_tick,
   output logic o_p_tick_pre
);
   localparam int W = $clog2(CLK_DIV);
   logic [W-1:0] r_div;
   logic         r_tick;
   // tick is registered from this so it is high exactly while r_div == CLK_DIV-1
   assign o_p_tick_pre = (r_div == W'(CLK_DIV - 2));
   assign o_p_tick     = r_tick;
   // divider counter; >= also recovers from an out-of-range count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= (r_div >= W'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
         r_tick <= o_p_tick_pre;
      end
   end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator (counters, sync decode, frame tick); VGA_SYNC_RGB_REG_EN adds a registered rgb path with matching sync delay
module vga_sync
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic               clk,
   input  logic               reset,
`ifdef VGA_SYNC_RGB_REG_EN
   input  logic [11:0]        rgb_in,
   output logic [11:0]        rgb,
`endif
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               p_tick,
   output logic               frame_tick,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y
);
   localparam int HT   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int VT   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_B = H_DISPLAY + H_FRONT;
   localparam int HS_E = HS_B + H_SYNC - 1;
   localparam int VS_B = V_DISPLAY + V_FRONT;
   localparam int VS_E = VS_B + V_SYNC - 1;
   logic               w_tick, w_tick_pre, w_h_end, w_v_end, w_hs, w_vs;
   logic [COORD_W-1:0] r_h, r_v, w_h_d, w_v_d;
   logic               r_hs, r_vs, r_ft;
   vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk          (clk),
      .reset        (reset),
      .o_p_tick     (w_tick),
      .o_p_tick_pre (w_tick_pre)
   );
   // next-state counters and sync decode from them, so sync has zero lag to the coordinates
   always_comb begin
      w_h_end = r_h >= COORD_W'(HT - 1);
      w_v_end = r_v >= COORD_W'(VT - 1);
      w_h_d   = w_tick ? (w_h_end ? '0 : r_h + 1'b1) : r_h;
      w_v_d   = (w_tick && w_h_end) ? (w_v_end ? '0 : r_v + 1'b1) : r_v;
      w_hs    = !(w_h_d >= COORD_W'(HS_B) && w_h_d <= COORD_W'(HS_E));
      w_vs    = !(w_v_d >= COORD_W'(VS_B) && w_v_d <= COORD_W'(VS_E));
   end
   // counters only move on tick edges, so the pre-tick cycle already sees the wrapping position
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h  <= '0;
         r_v  <= '0;
         r_hs <= 1'b1;
         r_vs <= 1'b1;
         r_ft <= 1'b0;
      end else begin
         r_h  <= w_h_d;
         r_v  <= w_v_d;
         r_hs <= w_hs;
         r_vs <= w_vs;
         r_ft <= w_tick_pre && w_h_end && w_v_end;
      end
   end
   assign video_on   = (r_h < COORD_W'(H_DISPLAY)) && (r_v < COORD_W'(V_DISPLAY));
   assign p_tick     = w_tick;
   assign frame_tick = r_ft;
   assign pixel_x    = r_h;
   assign pixel_y    = r_v;
`ifdef VGA_SYNC_RGB_REG_EN
   logic        r_hs_d, r_vs_d;
   logic [11:0] r_rgb;
   // rgb sample and one pixel-period sync delay so both leave aligned
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hs_d <= 1'b1;
         r_vs_d <= 1'b1;
         r_rgb  <= '0;
      end else if (w_tick) begin
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_rgb  <= video_on ? rgb_in : 12'h000;
      end
   end
   assign hsync = r_hs_d;
   assign vsync = r_vs_d;
   assign rgb   = r_rgb;
`else
   assign hsync = r_hs;
   assign vsync = r_vs;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench for vga_sync; a default instance plus a scaled-geometry instance (CLK_DIV=2) for whole-frame behaviour
module tb_vga_sync;
   typedef logic [36:0] vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hs0, vs0, vo0, pt0, ft0, hs1, vs1, vo1, pt1, ft1;
   logic [9:0] x0, y0, x1, y1;
   logic [11:0] rgb0, rgb1;
   int         checks = 0;
   int         failures = 0;
   vec_t       q0[$];
   vec_t       q1[$];

   always #5 clk = ~clk;

`ifdef VGA_SYNC_RGB_REG_EN
   logic [11:0] rgb_in = 12'hfff;
`else
   assign rgb0 = 12'h000;
   assign rgb1 = 12'h000;
`endif

   vga_sync dut (
      .clk(clk), .reset(reset),
`ifdef VGA_SYNC_RGB_REG_EN
      .rgb_in(rgb_in), .rgb(rgb0),
`endif
      .hsync(hs0), .vsync(vs0), .video_on(vo0), .p_tick(pt0), .frame_tick(ft0),
      .pixel_x(x0), .pixel_y(y0)
   );

   vga_sync #(
      .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) dut_s (
      .clk(clk), .reset(reset),
`ifdef VGA_SYNC_RGB_REG_EN
      .rgb_in(rgb_in), .rgb(rgb1),
`endif
      .hsync(hs1), .vsync(vs1), .video_on(vo1), .p_tick(pt1), .frame_tick(ft1),
      .pixel_x(x1), .pixel_y(y1)
   );

   // expected {x, y, hsync, vsync, video_on, p_tick, frame_tick, rgb} in cycle i (1 = first cycle after release)
   function automatic vec_t model(input int i, input int div, input int hd, input int hf, input int hw, input int hb,
                                  input int vd, input int vf, input int vw, input int vb);
      int ht, vt, n, m, x, y;
      logic pt, hs, vs, vo, ft;
      logic [11:0] rgb;
      ht  = hd + hf + hw + hb;
      vt  = vd + vf + vw + vb;
      n   = (i - 1) / div;
      x   = n % ht;
      y   = (n / ht) % vt;
      pt  = (i % div) == 0;
      vo  = (x < hd) && (y < vd);
      ft  = pt && (x == ht - 1) && (y == vt - 1);
      m   = n;
      rgb = 12'h000;
`ifdef VGA_SYNC_RGB_REG_EN
      m = n - 1;
      if (m >= 0 && (m % ht) < hd && ((m / ht) % vt) < vd) rgb = 12'hfff;
`endif
      hs = 1'b1;
      vs = 1'b1;
      if (m >= 0) begin
         hs = !((m % ht) >= hd + hf && (m % ht) < hd + hf + hw);
         vs = !(((m / ht) % vt) >= vd + vf && ((m / ht) % vt) < vd + vf + vw);
      end
      return {10'(x), 10'(y), hs, vs, vo, pt, ft, rgb};
   endfunction

   task automatic restart;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({x0, y0, hs0, vs0, vo0, pt0, ft0} !== {20'd0, 5'b11100}) begin
         failures++;
         $display("FAIL reset_default got=%h exp=%h", {x0, y0, hs0, vs0, vo0, pt0, ft0}, {20'd0, 5'b11100});
      end
      checks++;
      if ({x1, y1, hs1, vs1, vo1, pt1, ft1} !== {20'd0, 5'b11100}) begin
         failures++;
         $display("FAIL reset_small got=%h exp=%h", {x1, y1, hs1, vs1, vo1, pt1, ft1}, {20'd0, 5'b11100});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         checks++;
         if ({pt0, x0} !== {(i % 4) == 0, 10'((i - 1) / 4)}) begin
            failures++;
            $display("FAIL tick_div4 cyc=%0d got pt=%b x=%0d exp pt=%b x=%0d", i, pt0, x0, (i % 4) == 0, (i - 1) / 4);
         end
         checks++;
         if ({pt1, x1} !== {(i % 2) == 0, 10'((i - 1) / 2)}) begin
            failures++;
            $display("FAIL tick_div2 cyc=%0d got pt=%b x=%0d exp pt=%b x=%0d", i, pt1, x1, (i % 2) == 0, (i - 1) / 2);
         end
      end
   endtask

   task automatic test_line;
      vec_t got, exp;
      int   hs_low;
      hs_low = 0;
      restart();
      for (int i = 1; i <= 6600; i++) q0.push_back(model(i, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      for (int i = 1; i <= 6600; i++) begin
         @(negedge clk);
         exp = q0.pop_front();
         got = {x0, y0, hs0, vs0, vo0, pt0, ft0, rgb0};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL line cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i <= 3200 && pt0 && !hs0) hs_low++;
      end
      checks++;
      if (hs_low !== 96) begin
         failures++;
         $display("FAIL hsync_width got=%0d exp=96", hs_low);
      end
   endtask

   task automatic test_frame;
      vec_t got, exp;
      int   vs_low, ft_cnt, f1, f2;
      vs_low = 0;
      ft_cnt = 0;
      f1 = 0;
      f2 = 0;
      restart();
      for (int i = 1; i <= 790; i++) q1.push_back(model(i, 2, 8, 2, 3, 3, 6, 2, 2, 2));
      for (int i = 1; i <= 790; i++) begin
         @(negedge clk);
         exp = q1.pop_front();
         got = {x1, y1, hs1, vs1, vo1, pt1, ft1, rgb1};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL frame cyc=%0d got=%h exp=%h", i, got, exp);
         end
         if (i <= 384 && pt1 && !vs1) vs_low++;
         if (ft1) begin
            ft_cnt++;
            if (ft_cnt == 1) f1 = i;
            if (ft_cnt == 2) f2 = i;
         end
      end
      checks++;
      if (vs_low !== 32) begin
         failures++;
         $display("FAIL vsync_width got=%0d exp=32", vs_low);
      end
      checks++;
      if (ft_cnt !== 2 || f2 - f1 !== 384) begin
         failures++;
         $display("FAIL frame_tick_period got count=%0d gap=%0d exp count=2 gap=384", ft_cnt, f2 - f1);
      end
   endtask

   task automatic test_reset_mid_frame;
      vec_t got, exp;
      restart();
      repeat (279) @(negedge clk);
      checks++;
      if ({x1, y1, hs1, vs1} !== {10'd11, 10'd8, 2'b00}) begin
         failures++;
         $display("FAIL pre_reset_small got x=%0d y=%0d hs=%b vs=%b exp x=11 y=8 hs=0 vs=0", x1, y1, hs1, vs1);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({x1, y1, hs1, vs1, pt1, ft1} !== {20'd0, 4'b1100}) begin
         failures++;
         $display("FAIL async_reset_small got=%h exp=%h", {x1, y1, hs1, vs1, pt1, ft1}, {20'd0, 4'b1100});
      end
      restart();
      repeat (6001) @(negedge clk);
      checks++;
      if ({x0, y0, hs0} !== {10'd700, 10'd1, 1'b0}) begin
         failures++;
         $display("FAIL pre_reset_default got x=%0d y=%0d hs=%b exp x=700 y=1 hs=0", x0, y0, hs0);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({x0, y0, hs0, vs0, pt0, ft0} !== {20'd0, 4'b1100}) begin
         failures++;
         $display("FAIL async_reset_default got=%h exp=%h", {x0, y0, hs0, vs0, pt0, ft0}, {20'd0, 4'b1100});
      end
      restart();
      for (int i = 1; i <= 40; i++) q0.push_back(model(i, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         exp = q0.pop_front();
         got = {x0, y0, hs0, vs0, vo0, pt0, ft0, rgb0};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL restart cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
